d_sram_to_sram_like: RTL and testbench

- Data-side bridge directly downstream of the CPU datapath's memory stage.
- Converts the datapath's single-cycle SRAM-style access (enable, byte write-enables, address, write data, read data) into the split sram-like handshake (req/addr_ok/data_ok) used by the cache/AXI side.
- Generates the data-side stall that freezes the pipeline until the access completes.
- Holds the returned read data stable for as long as the global pipeline stall persists.

---
 rtl/d_sram_to_sram_like_pkg.sv | 15 +
 rtl/d_sram_to_sram_like.sv | 112 +++++++++++
 tb/tb_d_sram_to_sram_like.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/d_sram_to_sram_like_pkg.sv
// Shared definitions for the sram -> sram-like bridges (data side and instruction side).
package d_sram_to_sram_like_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/d_sram_to_sram_like.sv
// Data-side bridge: single-cycle SRAM access from the memory stage to a split
// req/addr_ok/data_ok transaction, stalling the pipeline until it completes.
module d_sram_to_sram_like
  import d_sram_to_sram_like_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic [3:0]        cpu_wen,
  input  logic [1:0]        cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              d_stall,
  input  logic              longest_stall,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic [DATA_W-1:0] data_rdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok
);

  state_t state;

  function automatic logic wen_legal(input logic [3:0] wen);
    case (wen)
      4'b1111, 4'b0011, 4'b1100,
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Illegal patterns fall back to a word transfer; the assertion below flags them.
  function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
    case (wen)
      4'b1111:                            return SZ_WORD;
      4'b0011, 4'b1100:                   return SZ_HALF;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return SZ_BYTE;
      default:                            return SZ_WORD;
    endcase
  endfunction

  assign data_req = (state == ADDR);

  always_comb begin
    d_stall = 1'b0;
    case (state)
      IDLE:    d_stall = cpu_en;
      ADDR:    d_stall = 1'b1;
      DATA:    d_stall = 1'b1;
      DONE:    d_stall = 1'b0;
      default: d_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cpu_rdata  <= '0;
      data_wr    <= 1'b0;
      data_size  <= SZ_BYTE;
      data_addr  <= '0;
      data_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_en) begin
            data_wr    <= |cpu_wen;
            data_size  <= (|cpu_wen) ? wen_to_size(cpu_wen) : cpu_size;
            data_addr  <= cpu_addr;
            data_wdata <= cpu_wdata;
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (data_addr_ok) begin
            if (data_data_ok) begin
              cpu_rdata <= data_rdata;
              state     <= DONE;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (data_data_ok) begin
            cpu_rdata <= data_rdata;
            state     <= DONE;
          end
        end
        DONE: begin
          // cpu_en is still high for the finished instruction; wait for the pipeline to move.
          if (!longest_stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_legal_wen: assert property (@(posedge clk) disable iff (rst)
    (state == IDLE && cpu_en && (|cpu_wen)) |-> wen_legal(cpu_wen));

  a_no_spurious_data_ok: assert property (@(posedge clk) disable iff (rst)
    (state == IDLE || state == DONE) |-> !data_data_ok);

endmodule

// File: tb/tb_d_sram_to_sram_like.sv
// Directed bench for d_sram_to_sram_like: a driver issues CPU accesses, a slave
// model answers the sram-like side, and a monitor scores requests and responses.
module tb_d_sram_to_sram_like;
  import d_sram_to_sram_like_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        d_stall;
  logic        longest_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  d_sram_to_sram_like #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .d_stall(d_stall), .longest_stall(longest_stall),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    int          req_len;
    int          stall_len;
  } rsp_t;

  typedef struct {
    logic [3:0]  wen;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ad;
    int          dd;
    int          hold;
    logic        garbage;
    logic [1:0]  exp_size;
    int          req_len;
    int          stall_len;
  } vec_t;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- slave model (sram-like side) ----------------
  int          cfg_ad = 0;
  int          cfg_dd = 1;
  logic [31:0] cfg_rdata = '0;

  initial begin
    int req_cnt;
    int dleft;
    bit pend;
    req_cnt = 0; dleft = 0; pend = 0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    forever begin
      @(negedge clk);
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      if (rst) begin
        pend = 0; req_cnt = 0;
      end else if (pend) begin
        dleft--;
        if (dleft == 0) begin
          data_data_ok = 1'b1; data_rdata = cfg_rdata; pend = 0;
        end
      end else if (data_req) begin
        if (req_cnt == cfg_ad) begin
          data_addr_ok = 1'b1;
          req_cnt = 0;
          if (cfg_dd == 0) begin
            data_data_ok = 1'b1; data_rdata = cfg_rdata;
          end else begin
            pend = 1; dleft = cfg_dd;
          end
        end else begin
          req_cnt++;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int          req_cycles = 0;
  int          stall_cycles = 0;
  bit          holding = 0;
  logic [31:0] hold_val = '0;

  initial begin
    req_t er;
    rsp_t es;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        req_cycles = 0; stall_cycles = 0; holding = 0;
      end else begin
        if (data_req) begin
          req_cycles++;
          if (exp_req_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req: data_req=1 addr=0x%08h with no access outstanding", data_addr);
          end else begin
            er = exp_req_q[0];
            check32("req_wr", {31'b0, data_wr}, {31'b0, er.wr});
            check32("req_size", {30'b0, data_size}, {30'b0, er.size});
            check32("req_addr", data_addr, er.addr);
            check32("req_wdata", data_wdata, er.wdata);
            if (data_addr_ok) void'(exp_req_q.pop_front());
          end
        end
        if (d_stall) begin
          stall_cycles++;
          holding = 0;
        end else if (cpu_en && stall_cycles > 0) begin
          if (exp_rsp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: cpu_rdata=0x%08h with no response expected", cpu_rdata);
          end else begin
            es = exp_rsp_q.pop_front();
            check32("cpu_rdata", cpu_rdata, es.rdata);
            check32("req_len", req_cycles, es.req_len);
            check32("stall_len", stall_cycles, es.stall_len);
            hold_val = es.rdata;
            holding = 1;
          end
          req_cycles = 0; stall_cycles = 0;
        end else if (cpu_en && holding) begin
          check32("rdata_hold", cpu_rdata, hold_val);
        end else if (!cpu_en) begin
          holding = 0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  vec_t vecs[8];

  function automatic vec_t mk(input logic [3:0] wen, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int ad, input int dd,
                              input int hold, input logic garbage, input logic [1:0] exp_size,
                              input int req_len, input int stall_len);
    vec_t v;
    v.wen = wen; v.size = size; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.ad = ad; v.dd = dd; v.hold = hold; v.garbage = garbage; v.exp_size = exp_size;
    v.req_len = req_len; v.stall_len = stall_len;
    return v;
  endfunction

  // Called just after a posedge; returns just after the edge that leaves DONE,
  // with cpu_en still high so the caller may chain the next access.
  task automatic run_access(input int i);
    vec_t v;
    req_t r;
    rsp_t s;
    int   hold_left;
    bit   done;
    v = vecs[i];
    cfg_ad = v.ad; cfg_dd = v.dd; cfg_rdata = v.rdata;
    r.wr = |v.wen; r.size = v.exp_size; r.addr = v.addr; r.wdata = v.wdata;
    exp_req_q.push_back(r);
    s.rdata = v.rdata; s.req_len = v.req_len; s.stall_len = v.stall_len;
    exp_rsp_q.push_back(s);
    cpu_en = 1'b1; cpu_wen = v.wen; cpu_size = v.size; cpu_addr = v.addr; cpu_wdata = v.wdata;
    hold_left = v.hold;
    done = 0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      @(posedge clk); #1;
      if (d_stall) begin
        if (v.garbage) begin
          cpu_addr = $urandom; cpu_wdata = $urandom;
        end
      end else if (hold_left > 0) begin
        longest_stall = 1'b1;
        hold_left--;
      end else begin
        longest_stall = 1'b0;
        done = 1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout: access %0d did not complete within 100 cycles", i);
      cpu_en = 1'b0; longest_stall = 1'b0;
      return;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    cpu_en = 1'b0; cpu_wen = 4'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    req_t r;
    //                wen      size  addr          wdata         rdata         ad dd hold garb  esz   rl sl
    vecs[0] = mk(4'b0000, 2'd2, 32'h0000_1000, 32'h0000_0000, 32'hDEAD_BEEF, 0, 1, 0, 1'b0, 2'd2, 1, 3);
    vecs[1] = mk(4'b0100, 2'd2, 32'h0000_2002, 32'h00AB_0000, 32'h1111_1111, 0, 1, 0, 1'b0, 2'd0, 1, 3);
    vecs[2] = mk(4'b0000, 2'd1, 32'h0000_3002, 32'h0000_0000, 32'h0000_BEEF, 3, 1, 0, 1'b1, 2'd1, 4, 6);
    vecs[3] = mk(4'b0000, 2'd2, 32'h0000_4000, 32'h0000_0000, 32'h1234_5678, 0, 1, 5, 1'b0, 2'd2, 1, 3);
    vecs[4] = mk(4'b1100, 2'd0, 32'h0000_6002, 32'hCAFE_0000, 32'h0BAD_F00D, 1, 2, 0, 1'b0, 2'd1, 2, 5);
    vecs[5] = mk(4'b1111, 2'd0, 32'h0000_7000, 32'h0102_0304, 32'h2222_2222, 0, 1, 0, 1'b0, 2'd2, 1, 3);
    vecs[6] = mk(4'b0000, 2'd0, 32'h0000_5001, 32'h0000_0000, 32'h5A5A_5A5A, 0, 0, 0, 1'b0, 2'd0, 1, 2);
    vecs[7] = mk(4'b0000, 2'd2, 32'h0000_8000, 32'h0000_0000, 32'h7777_7777, 0, 20, 0, 1'b0, 2'd2, 1, 0);

    rst = 1'b1; cpu_en = 1'b0; cpu_wen = 4'b0; cpu_size = 2'd0;
    cpu_addr = '0; cpu_wdata = '0; longest_stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_data_req", {31'b0, data_req}, 32'd0);
    check32("rst_d_stall", {31'b0, d_stall}, 32'd0);
    check32("rst_cpu_rdata", cpu_rdata, 32'd0);
    check32("rst_data_wr", {31'b0, data_wr}, 32'd0);
    check32("rst_data_size", {30'b0, data_size}, 32'd0);
    check32("rst_data_addr", data_addr, 32'd0);
    check32("rst_data_wdata", data_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_access(0);            // word read, minimum latency
    idle_cycle();
    run_access(1);            // byte write, chained straight into the next access
    run_access(2);            // delayed addr_ok with garbage on cpu_addr
    idle_cycle();
    run_access(3);            // long global stall after completion
    idle_cycle();
    run_access(4);            // half write
    run_access(5);            // word write, back-to-back
    idle_cycle();
    run_access(6);            // addr_ok and data_ok together
    idle_cycle();

    // Reset while the access sits in DATA.
    cfg_ad = vecs[7].ad; cfg_dd = vecs[7].dd; cfg_rdata = vecs[7].rdata;
    r.wr = 1'b0; r.size = vecs[7].exp_size; r.addr = vecs[7].addr; r.wdata = vecs[7].wdata;
    exp_req_q.push_back(r);
    cpu_en = 1'b1; cpu_wen = vecs[7].wen; cpu_size = vecs[7].size;
    cpu_addr = vecs[7].addr; cpu_wdata = vecs[7].wdata;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check32("data_state_stall", {31'b0, d_stall}, 32'd1);
    check32("data_state_req", {31'b0, data_req}, 32'd0);
    rst = 1'b1; cpu_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check32("post_rst_data_req", {31'b0, data_req}, 32'd0);
    check32("post_rst_d_stall", {31'b0, d_stall}, 32'd0);
    check32("post_rst_cpu_rdata", cpu_rdata, 32'd0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check32("post_rst_no_req", {31'b0, data_req}, 32'd0);

    check32("req_queue_empty", exp_req_q.size(), 32'd0);
    check32("rsp_queue_empty", exp_rsp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
